// File: rtl/div_result_display.sv
// Seven-segment viewer for the 4-bit divider result byte: alternates quotient/remainder, shows "E" for 8'hFF.
// Optional macro RESULT_BLINK_EN makes the error glyph blink at the hold rate instead of staying steady.
module div_result_display #(
  parameter int HOLD_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] res_in,
  input  logic       res_valid,
  output logic [6:0] seg,
  output logic       dp,
  output logic       digit_sel
);

  localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_Q = 2'd1,
    SHOW_R = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [7:0]      res_q_r, res_q_s;
  logic            blank_r, blank_s;
  logic [6:0]      seg_s;
  logic            dp_s;
  logic            digit_sel_s;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Next-state: capture beats hold expiry; with ena low everything simply holds.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    res_q_s = res_q_r;
    blank_s = blank_r;
    if (!ena) begin
      state_s = state_r;
    end else if (res_valid) begin
      res_q_s = res_in;
      cnt_s   = CNT_ZERO;
      blank_s = 1'b0;
      state_s = (res_in == 8'hFF) ? ERR : SHOW_Q;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_s = CNT_ZERO;
        end
        SHOW_Q: begin
          if (cnt_r == CNT_LAST) begin
            state_s = SHOW_R;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        SHOW_R: begin
          if (cnt_r == CNT_LAST) begin
            state_s = SHOW_Q;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ERR: begin
`ifdef RESULT_BLINK_EN
          if (cnt_r == CNT_LAST) begin
            cnt_s   = CNT_ZERO;
            blank_s = ~blank_r;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
`else
          cnt_s   = CNT_ZERO;
          blank_s = 1'b0;
`endif
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          blank_s = 1'b0;
        end
      endcase
    end
  end

  // Output decode from the next state so the display changes on the same edge as the state.
  always_comb begin
    seg_s       = 7'h00;
    dp_s        = 1'b0;
    digit_sel_s = 1'b0;
    case (state_s)
      IDLE: begin
        seg_s = 7'h00;
      end
      SHOW_Q: begin
        seg_s = hex7(res_q_s[7:4]);
      end
      SHOW_R: begin
        seg_s       = hex7(res_q_s[3:0]);
        dp_s        = 1'b1;
        digit_sel_s = 1'b1;
      end
      ERR: begin
        seg_s = blank_s ? 7'h00 : 7'h79;
        dp_s  = ~blank_s;
      end
      default: begin
        seg_s = 7'h00;
      end
    endcase
  end

  // State, hold counter, capture register and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      res_q_r   <= 8'h00;
      blank_r   <= 1'b0;
      seg       <= 7'h00;
      dp        <= 1'b0;
      digit_sel <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      res_q_r   <= res_q_s;
      blank_r   <= blank_s;
      seg       <= seg_s;
      dp        <= dp_s;
      digit_sel <= digit_sel_s;
    end
  end

endmodule
